int_controller: RTL and testbench

Interrupt request controller for the CTI-8 core; it produces the INT line that the status lights and CPU consume.
- Synchronizes and edge-detects up to NUM_SRC device request lines, latches them as pending, and applies a bus-writable mask.
- Raises INT to the CPU and runs an INT/inta acknowledge handshake.
- During acknowledge, presents a vector for the highest-priority source and clears that source's pending bit.

---
 rtl/int_controller.sv | 173 +++++++++++++++++
 tb/tb_int_controller.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_controller.sv
// Interrupt request controller: synchronised edge capture, MASK/PEND registers, INT/inta handshake.
// Define PRIORITY_ROTATE_EN for round-robin source priority; default is fixed lowest-index-first.
module int_controller #(
    parameter int          NUM_SRC  = 8,
    parameter logic [7:0]  VEC_BASE = 8'h10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq,
    input  logic               cs,
    input  logic               wr,
    input  logic               addr,
    input  logic [7:0]         wdata,
    output logic [7:0]         rdata,
    output logic               INT,
    input  logic               inta,
    output logic [7:0]         vector
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK
    } state_t;

    state_t             r_state;
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;
    logic [NUM_SRC-1:0] r_sync3;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_pend;
    logic               r_int;
    logic [7:0]         r_vector;
`ifdef PRIORITY_ROTATE_EN
    logic [IW-1:0]      r_last_k;
`endif

    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_active;
    logic [NUM_SRC-1:0] w_pend_next;
    logic [IW-1:0]      w_win;
    logic               w_take;
    logic               w_mask_wr;
    logic               w_pend_wr;

    assign w_edge    = r_sync2 & ~r_sync3;
    assign w_active  = r_pend & r_mask;
    assign w_mask_wr = cs & wr & ~addr;
    assign w_pend_wr = cs & wr & addr;
    assign w_take    = (r_state == REQ) && (w_active != '0) && inta;

    assign INT    = r_int;
    assign vector = r_vector;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sync3 <= '0;
        end else begin
            r_sync1 <= irq;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Scanning from the far end lets the nearest candidate overwrite earlier hits.
`ifdef PRIORITY_ROTATE_EN
    always_comb begin
        int idx;
        w_win = '0;
        idx   = 0;
        for (int j = NUM_SRC - 1; j >= 0; j--) begin
            idx = int'(r_last_k) + 1 + j;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (w_active[IW'(idx)]) begin
                w_win = IW'(idx);
            end
        end
    end
`else
    always_comb begin
        w_win = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_active[IW'(i)]) begin
                w_win = IW'(i);
            end
        end
    end
`endif

    // A fresh edge is applied last so it survives both W1C and acknowledge clears.
    always_comb begin
        w_pend_next = r_pend;
        if (w_pend_wr) begin
            w_pend_next = w_pend_next & ~wdata[NUM_SRC-1:0];
        end
        if (w_take) begin
            w_pend_next[w_win] = 1'b0;
        end
        w_pend_next = w_pend_next | w_edge;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask <= '0;
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
            if (w_mask_wr) begin
                r_mask <= wdata[NUM_SRC-1:0];
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (addr) begin
            rdata[NUM_SRC-1:0] = r_pend;
        end else begin
            rdata[NUM_SRC-1:0] = r_mask;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_int    <= 1'b0;
            r_vector <= 8'h00;
`ifdef PRIORITY_ROTATE_EN
            r_last_k <= IW'(NUM_SRC - 1);
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_active != '0) begin
                        r_state <= REQ;
                        r_int   <= 1'b1;
                    end
                end
                REQ: begin
                    if (w_active == '0) begin
                        r_state <= IDLE;
                        r_int   <= 1'b0;
                    end else if (inta) begin
                        r_state  <= ACK;
                        r_int    <= 1'b0;
                        r_vector <= VEC_BASE + 8'(w_win);
`ifdef PRIORITY_ROTATE_EN
                        r_last_k <= w_win;
`endif
                    end
                end
                ACK: begin
                    if (!inta) begin
                        r_state  <= IDLE;
                        r_vector <= 8'h00;
                    end
                end
                default: begin
                    r_state  <= IDLE;
                    r_int    <= 1'b0;
                    r_vector <= 8'h00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_int_controller.sv
// Self-checking bench for int_controller: directed scenarios followed by randomized traffic
// compared every cycle against a behavioural reference model.
module tb_int_controller;

    localparam int         NUM_SRC  = 8;
    localparam logic [7:0] VEC_BASE = 8'h10;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] irq   = 8'h00;
    logic       cs    = 1'b0;
    logic       wr    = 1'b0;
    logic       addr  = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       INT;
    logic       inta  = 1'b0;
    logic [7:0] vector;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: pending/mask sets, a two-step delay line for captured edges,
    // and flags for "asking the CPU" and "serving an acknowledge".
    bit [7:0] mPend, mMask, lastSamp, d1, d2, mVec;
    bit       mRequesting, mServing;
    int       mLastK;

    always #5 clk = ~clk;

    int_controller #(
        .NUM_SRC  (NUM_SRC),
        .VEC_BASE (VEC_BASE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .irq    (irq),
        .cs     (cs),
        .wr     (wr),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .INT    (INT),
        .inta   (inta),
        .vector (vector)
    );

    function automatic int pickSource(input bit [7:0] act);
        int start;
`ifdef PRIORITY_ROTATE_EN
        start = (mLastK + 1) % NUM_SRC;
`else
        start = 0;
`endif
        for (int j = 0; j < NUM_SRC; j++) begin
            if (act[(start + j) % NUM_SRC]) return (start + j) % NUM_SRC;
        end
        return 0;
    endfunction

    task automatic modelReset();
        mPend = 0; mMask = 0; lastSamp = 0; d1 = 0; d2 = 0; mVec = 0;
        mRequesting = 0; mServing = 0; mLastK = NUM_SRC - 1;
    endtask

    task automatic modelClock();
        bit [7:0] act, setNow, nextPend;
        int k;
        if (!reset) begin
            modelReset();
            return;
        end
        act      = mPend & mMask;
        setNow   = d2;
        d2       = d1;
        d1       = irq & ~lastSamp;
        lastSamp = irq;
        nextPend = mPend;
        if (cs && wr && addr) nextPend = nextPend & ~wdata;
        if (mServing) begin
            if (!inta) begin
                mServing = 0;
                mVec     = 8'h00;
            end
        end else if (mRequesting) begin
            if (act == 0) begin
                mRequesting = 0;
            end else if (inta) begin
                k = pickSource(act);
                mRequesting = 0;
                mServing    = 1;
                mVec        = VEC_BASE + 8'(k);
                nextPend[k] = 1'b0;
                mLastK      = k;
            end
        end else if (act != 0) begin
            mRequesting = 1;
        end
        mPend = nextPend | setNow;
        if (cs && wr && !addr) mMask = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        checkOutput("INT",    {7'b0, INT}, {7'b0, mRequesting});
        checkOutput("vector", vector, mVec);
        checkOutput("rdata",  rdata, addr ? mPend : mMask);
    endtask

    task automatic tick();
        @(posedge clk);
        modelClock();
        #1;
        checkAll();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input logic a, input logic [7:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        tick();
        cs = 1'b0; wr = 1'b0;
    endtask

    initial begin
        logic [2:0] bitSel;

        // Reset state, checked before any clock edge.
        #1 reset = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_INT",    {7'b0, INT}, 8'h00);
        checkOutput("rst_vector", vector, 8'h00);
        checkOutput("rst_mask",   rdata, 8'h00);
        addr = 1'b1;
        #1;
        checkOutput("rst_pend",   rdata, 8'h00);
        reset = 1'b1;

        // Single source with four-cycle request latency.
        applyStimulus(1'b0, 8'h04);
        irq[2] = 1'b1;
        addr   = 1'b1;
        ticks(3);
        checkOutput("lat3_INT",  {7'b0, INT}, 8'h00);
        checkOutput("lat3_pend", rdata, 8'h04);
        tick();
        checkOutput("lat4_INT",  {7'b0, INT}, 8'h01);
        inta = 1'b1;
        tick();
        checkOutput("ack_vec2",  vector, 8'h12);
        checkOutput("ack_pend2", rdata, 8'h00);
        checkOutput("ack_INT2",  {7'b0, INT}, 8'h00);
        inta = 1'b0;
        tick();
        checkOutput("rel_vec2",  vector, 8'h00);
        checkOutput("rel_INT2",  {7'b0, INT}, 8'h00);
        irq = 8'h00;
        tick();

        // Masked source becomes active once enabled.
        applyStimulus(1'b0, 8'h00);
        irq[5] = 1'b1;
        addr   = 1'b1;
        ticks(5);
        checkOutput("msk_pend", rdata, 8'h20);
        checkOutput("msk_INT",  {7'b0, INT}, 8'h00);
        applyStimulus(1'b0, 8'h20);
        tick();
        checkOutput("unmsk_INT", {7'b0, INT}, 8'h01);
        inta = 1'b1;
        tick();
        checkOutput("ack_vec5", vector, 8'h15);
        inta = 1'b0;
        irq  = 8'h00;
        ticks(2);

        // Two simultaneous sources, back-to-back acknowledges.
        applyStimulus(1'b0, 8'hFF);
        irq = 8'h42;
        ticks(4);
        checkOutput("pri_INT", {7'b0, INT}, 8'h01);
        inta = 1'b1;
        tick();
`ifdef PRIORITY_ROTATE_EN
        checkOutput("pri_first", vector, 8'h16);
`else
        checkOutput("pri_first", vector, 8'h11);
`endif
        inta = 1'b0;
        tick();
        checkOutput("gap_INT", {7'b0, INT}, 8'h00);
        tick();
        checkOutput("b2b_INT", {7'b0, INT}, 8'h01);
        inta = 1'b1;
        tick();
`ifdef PRIORITY_ROTATE_EN
        checkOutput("pri_second", vector, 8'h11);
`else
        checkOutput("pri_second", vector, 8'h16);
`endif
        inta = 1'b0;
        irq  = 8'h00;
        ticks(2);

        // Request withdrawn by W1C before the CPU acknowledges.
        irq = 8'h01;
        ticks(4);
        checkOutput("wd_INT_hi", {7'b0, INT}, 8'h01);
        applyStimulus(1'b1, 8'h01);
        tick();
        checkOutput("wd_INT_lo", {7'b0, INT}, 8'h00);
        inta = 1'b1;
        ticks(2);
        checkOutput("wd_vec", vector, 8'h00);
        inta = 1'b0;
        irq  = 8'h00;
        tick();

        // Asynchronous reset while serving an acknowledge.
        irq = 8'h08;
        ticks(4);
        inta = 1'b1;
        tick();
        checkOutput("ack_vec3", vector, 8'h13);
        #2;
        addr  = 1'b0;
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("arst_vec",  vector, 8'h00);
        checkOutput("arst_INT",  {7'b0, INT}, 8'h00);
        checkOutput("arst_mask", rdata, 8'h00);
        irq  = 8'h00;
        inta = 1'b0;
        #1 reset = 1'b1;
        ticks(2);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                bitSel = 3'($urandom_range(0, 7));
                irq[bitSel] = ~irq[bitSel];
            end
            cs    = ($urandom_range(0, 7) == 0);
            wr    = cs && ($urandom_range(0, 1) == 1);
            addr  = ($urandom_range(0, 1) == 1);
            wdata = 8'($urandom);
            if (inta) inta = ($urandom_range(0, 3) != 0);
            else if (INT) inta = ($urandom_range(0, 2) == 0);
            else inta = ($urandom_range(0, 19) == 0);
            if (c == 750) begin
                #2 reset = 1'b0;
                modelReset();
                #1;
                checkAll();
                #1 reset = 1'b1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
